// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 set-2 scan-code decoder.
// Holds the decoder state encoding, the protocol byte constants, the
// modifier key codes, the bit positions inside the modifier vector and
// small byte-classification helpers used by the decoder.
package ps2_pkg;

  // Decoder sequence states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GOT_E0     = 3'd1,
    ST_GOT_F0     = 3'd2,
    ST_GOT_E0F0   = 3'd3,
    ST_PAUSE_SKIP = 3'd4
  } ps2_state_e;

  // Prefix and control bytes
  localparam logic [7:0] BYTE_E0  = 8'hE0;  // extended prefix
  localparam logic [7:0] BYTE_F0  = 8'hF0;  // break prefix
  localparam logic [7:0] BYTE_E1  = 8'hE1;  // Pause sequence start
  localparam logic [7:0] BYTE_AA  = 8'hAA;  // BAT passed
  localparam logic [7:0] BYTE_FA  = 8'hFA;  // acknowledge
  localparam logic [7:0] BYTE_EE  = 8'hEE;  // echo
  localparam logic [7:0] BYTE_NUL = 8'h00;  // key detection error / overrun
  localparam logic [7:0] BYTE_FF  = 8'hFF;  // key detection error / overrun

  // Modifier key codes (left and right variants share one state bit)
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  // Bit positions inside o_Mods = {alt, ctrl, shift}
  localparam int unsigned MOD_SHIFT = 0;
  localparam int unsigned MOD_CTRL  = 1;
  localparam int unsigned MOD_ALT   = 2;

  // Bytes that follow E1 in a complete Pause sequence
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  // True for any byte that starts or continues a prefix sequence
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == BYTE_E0) || (b == BYTE_F0) || (b == BYTE_E1);
  endfunction

  // True for either shift key code (also the fake-shift codes after E0)
  function automatic logic is_shift_code(input logic [7:0] b);
    return (b == CODE_LSHIFT) || (b == CODE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational set-2 scan code to ASCII translation for a
// basic key subset (letters, digits, space, enter, backspace).
// Ports:
//   code  [7:0] in  non-extended scan code
//   shift       in  shift held; selects uppercase for letters only
//   ascii [7:0] out ASCII character, 8'h00 when the code is unmapped
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base_s;
  logic       letter_s;

  // Lowercase / unshifted character for each mapped code
  always_comb begin
    base_s = 8'h00;
    case (code)
      8'h1C: base_s = 8'h61;  8'h32: base_s = 8'h62;  8'h21: base_s = 8'h63;
      8'h23: base_s = 8'h64;  8'h24: base_s = 8'h65;  8'h2B: base_s = 8'h66;
      8'h34: base_s = 8'h67;  8'h33: base_s = 8'h68;  8'h43: base_s = 8'h69;
      8'h3B: base_s = 8'h6A;  8'h42: base_s = 8'h6B;  8'h4B: base_s = 8'h6C;
      8'h3A: base_s = 8'h6D;  8'h31: base_s = 8'h6E;  8'h44: base_s = 8'h6F;
      8'h4D: base_s = 8'h70;  8'h15: base_s = 8'h71;  8'h2D: base_s = 8'h72;
      8'h1B: base_s = 8'h73;  8'h2C: base_s = 8'h74;  8'h3C: base_s = 8'h75;
      8'h2A: base_s = 8'h76;  8'h1D: base_s = 8'h77;  8'h22: base_s = 8'h78;
      8'h35: base_s = 8'h79;  8'h1A: base_s = 8'h7A;
      8'h45: base_s = 8'h30;  8'h16: base_s = 8'h31;  8'h1E: base_s = 8'h32;
      8'h26: base_s = 8'h33;  8'h25: base_s = 8'h34;  8'h2E: base_s = 8'h35;
      8'h36: base_s = 8'h36;  8'h3D: base_s = 8'h37;  8'h3E: base_s = 8'h38;
      8'h46: base_s = 8'h39;
      8'h29: base_s = 8'h20;
      8'h5A: base_s = 8'h0D;
      8'h66: base_s = 8'h08;
      default: base_s = 8'h00;
    endcase
  end

  // Only letters react to shift; uppercase is lowercase minus 0x20
  always_comb begin
    letter_s = (base_s >= 8'h61) && (base_s <= 8'h7A);
    if (letter_s && shift) begin
      ascii = base_s - 8'h20;
    end else begin
      ascii = base_s;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns the PS/2 set-2 byte stream into key events.
// Resolves E0 / F0 / E0 F0 prefixes and the 8-byte E1 Pause sequence,
// drops fake-shift codes, tracks modifier state, flags typematic repeats
// and translates a basic key subset to ASCII.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_Byte, i_ByteValid received byte and its one-cycle strobe
//   o_EventValid       one-cycle strobe, event fields valid (held after)
//   o_Code, o_Extended, o_Break, o_Repeat, o_Ascii  event fields
//   o_Mods             {alt, ctrl, shift} held state
//   o_Error            one-cycle strobe on protocol error or timeout
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_Byte,
  input  logic       i_ByteValid,
  output logic       o_EventValid,
  output logic [7:0] o_Code,
  output logic       o_Extended,
  output logic       o_Break,
  output logic       o_Repeat,
  output logic [7:0] o_Ascii,
  output logic [2:0] o_Mods,
  output logic       o_Error
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_r;
  logic [2:0]       skip_r;
  logic [CNT_W-1:0] cnt_r;
  logic [8:0]       last_key_r;   // {ext, code} of the most recent make
  logic             last_valid_r;

  logic       ev_emit_s;
  logic       ev_err_s;
  logic       ev_ext_s;
  logic       ev_brk_s;
  logic [7:0] ev_code_s;
  logic [8:0] ev_key_s;
  logic       ev_repeat_s;
  logic [7:0] ev_ascii_s;
  logic [7:0] lut_ascii_s;
  logic [2:0] mods_nxt_s;
  logic       timeout_s;

  // Shift state before the event decides letter case
  ps2_ascii_lut u_lut (
    .code  (ev_code_s),
    .shift (o_Mods[MOD_SHIFT]),
    .ascii (lut_ascii_s)
  );

  // Decode what the current strobed byte completes: event, error or nothing
  always_comb begin
    ev_emit_s = 1'b0;
    ev_err_s  = 1'b0;
    ev_ext_s  = 1'b0;
    ev_brk_s  = 1'b0;
    ev_code_s = i_Byte;
    if (i_ByteValid) begin
      case (state_r)
        ST_IDLE: begin
          case (i_Byte)
            BYTE_E0, BYTE_F0, BYTE_E1,
            BYTE_AA, BYTE_FA, BYTE_EE: ev_emit_s = 1'b0;
            BYTE_NUL, BYTE_FF:         ev_err_s  = 1'b1;
            default:                   ev_emit_s = 1'b1;
          endcase
        end
        ST_GOT_E0: begin
          if (i_Byte == BYTE_F0) begin
            ev_emit_s = 1'b0;
          end else if (is_prefix(i_Byte)) begin
            ev_err_s = 1'b1;
          end else if (is_shift_code(i_Byte)) begin
            ev_emit_s = 1'b0;  // fake shift around extended keys
          end else begin
            ev_emit_s = 1'b1;
            ev_ext_s  = 1'b1;
          end
        end
        ST_GOT_F0: begin
          if (is_prefix(i_Byte)) begin
            ev_err_s = 1'b1;
          end else begin
            ev_emit_s = 1'b1;
            ev_brk_s  = 1'b1;
          end
        end
        ST_GOT_E0F0: begin
          if (is_prefix(i_Byte)) begin
            ev_err_s = 1'b1;
          end else if (is_shift_code(i_Byte)) begin
            ev_emit_s = 1'b0;
          end else begin
            ev_emit_s = 1'b1;
            ev_ext_s  = 1'b1;
            ev_brk_s  = 1'b1;
          end
        end
        ST_PAUSE_SKIP: begin
          if (skip_r == 3'd1) begin
            ev_emit_s = 1'b1;
            ev_code_s = BYTE_E1;
          end else begin
            ev_emit_s = 1'b0;
          end
        end
        default: ev_emit_s = 1'b0;
      endcase
    end else begin
      ev_emit_s = 1'b0;
    end
  end

  // Event side data: repeat flag, ASCII, timeout and next modifier state
  always_comb begin
    ev_key_s    = {ev_ext_s, ev_code_s};
    ev_repeat_s = !ev_brk_s && last_valid_r && (ev_key_s == last_key_r);
    if (!ev_ext_s && !ev_brk_s && (state_r != ST_PAUSE_SKIP)) begin
      ev_ascii_s = lut_ascii_s;
    end else begin
      ev_ascii_s = 8'h00;
    end
    timeout_s = !i_ByteValid && (state_r != ST_IDLE) && (cnt_r == TIMEOUT_LAST);
    mods_nxt_s = o_Mods;
    if (ev_emit_s && !ev_ext_s && is_shift_code(ev_code_s)) begin
      mods_nxt_s[MOD_SHIFT] = !ev_brk_s;
    end else begin
      mods_nxt_s[MOD_SHIFT] = o_Mods[MOD_SHIFT];
    end
    if (ev_emit_s && (ev_code_s == CODE_CTRL)) begin
      mods_nxt_s[MOD_CTRL] = !ev_brk_s;
    end else begin
      mods_nxt_s[MOD_CTRL] = o_Mods[MOD_CTRL];
    end
    if (ev_emit_s && (ev_code_s == CODE_ALT)) begin
      mods_nxt_s[MOD_ALT] = !ev_brk_s;
    end else begin
      mods_nxt_s[MOD_ALT] = o_Mods[MOD_ALT];
    end
  end

  // Sequence FSM, timeout counter, repeat tracking and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      skip_r       <= 3'd0;
      cnt_r        <= {CNT_W{1'b0}};
      last_key_r   <= 9'd0;
      last_valid_r <= 1'b0;
      o_EventValid <= 1'b0;
      o_Code       <= 8'h00;
      o_Extended   <= 1'b0;
      o_Break      <= 1'b0;
      o_Repeat     <= 1'b0;
      o_Ascii      <= 8'h00;
      o_Mods       <= 3'b000;
      o_Error      <= 1'b0;
    end else begin
      o_EventValid <= ev_emit_s;
      o_Error      <= ev_err_s | timeout_s;
      o_Mods       <= mods_nxt_s;
      if (ev_emit_s) begin
        o_Code     <= ev_code_s;
        o_Extended <= ev_ext_s;
        o_Break    <= ev_brk_s;
        o_Repeat   <= ev_repeat_s;
        o_Ascii    <= ev_ascii_s;
      end

      if (ev_emit_s && !ev_brk_s) begin
        last_key_r   <= ev_key_s;
        last_valid_r <= 1'b1;
      end else if (ev_emit_s && (ev_key_s == last_key_r)) begin
        last_valid_r <= 1'b0;
      end

      // A strobe always takes priority over a timeout in the same cycle
      if (i_ByteValid) begin
        cnt_r <= {CNT_W{1'b0}};
        case (state_r)
          ST_IDLE: begin
            if (i_Byte == BYTE_E0) begin
              state_r <= ST_GOT_E0;
            end else if (i_Byte == BYTE_F0) begin
              state_r <= ST_GOT_F0;
            end else if (i_Byte == BYTE_E1) begin
              state_r <= ST_PAUSE_SKIP;
              skip_r  <= PAUSE_SKIP_LEN;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_GOT_E0: begin
            if (i_Byte == BYTE_F0) begin
              state_r <= ST_GOT_E0F0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_PAUSE_SKIP: begin
            if (skip_r == 3'd1) begin
              state_r <= ST_IDLE;
            end else begin
              skip_r <= skip_r - 3'd1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (timeout_s) begin
        state_r <= ST_IDLE;
        cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r != ST_IDLE) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: a sequence-level model
// (whole received sequences classified by the protocol rules) checked
// against the DUT every cycle, plus directed literal expectations.
module tb_ps2_scancode_decoder;

  localparam int T = 40;

  // Mapped codes: 26 letters a..z, 10 digits 0..9, then space/enter/backspace
  localparam logic [7:0] KEY_TAB [0:38] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h29, 8'h5A, 8'h66};

  localparam int C_INC = 0, C_DISC = 1, C_ERR = 2, C_EVT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       o_EventValid, o_Extended, o_Break, o_Repeat, o_Error;
  logic [7:0] o_Code, o_Ascii;
  logic [2:0] o_Mods;

  int n_tests = 0;
  int n_fail = 0;
  int ev_seen = 0;
  int err_seen = 0;

  // Model state
  logic [7:0] seq[$];
  int         idle_cnt;
  logic [2:0] m_mods;
  logic [8:0] m_last;
  logic       m_last_v;
  logic       x_ev, x_err, x_ext, x_brk, x_rep;
  logic [7:0] x_code, x_ascii;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_Byte(din), .i_ByteValid(din_valid),
    .o_EventValid(o_EventValid), .o_Code(o_Code), .o_Extended(o_Extended),
    .o_Break(o_Break), .o_Repeat(o_Repeat), .o_Ascii(o_Ascii),
    .o_Mods(o_Mods), .o_Error(o_Error));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic sh);
    for (int i = 0; i < 39; i++) begin
      if (KEY_TAB[i] == c) begin
        if (i < 26) return sh ? 8'(8'h41 + i) : 8'(8'h61 + i);
        if (i < 36) return 8'(8'h30 + i - 26);
        if (i == 36) return 8'h20;
        if (i == 37) return 8'h0D;
        return 8'h08;
      end
    end
    return 8'h00;
  endfunction

  // Classify a whole byte sequence by the protocol rules
  function automatic int classify(input logic [7:0] s[$], output logic ext,
                                  output logic brk, output logic [7:0] c);
    int n;
    logic [7:0] b;
    logic pfx;
    n = s.size();
    b = s[n-1];
    pfx = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    ext = 1'b0; brk = 1'b0; c = b;
    if (s[0] == 8'hE1) begin
      if (n < 8) return C_INC;
      c = 8'hE1;
      return C_EVT;
    end
    if (n == 1) begin
      if (b == 8'hE0 || b == 8'hF0) return C_INC;
      if (b == 8'hAA || b == 8'hFA || b == 8'hEE) return C_DISC;
      if (b == 8'h00 || b == 8'hFF) return C_ERR;
      return C_EVT;
    end
    if (s[0] == 8'hF0) begin
      if (pfx) return C_ERR;
      brk = 1'b1;
      return C_EVT;
    end
    if (n == 2) begin
      if (b == 8'hF0) return C_INC;
      if (pfx) return C_ERR;
      if (b == 8'h12 || b == 8'h59) return C_DISC;
      ext = 1'b1;
      return C_EVT;
    end
    if (pfx) return C_ERR;
    if (b == 8'h12 || b == 8'h59) return C_DISC;
    ext = 1'b1; brk = 1'b1;
    return C_EVT;
  endfunction

  task automatic model_reset();
    seq.delete();
    idle_cnt = 0; m_mods = 3'b000; m_last = 9'd0; m_last_v = 1'b0;
    x_ev = 1'b0; x_err = 1'b0; x_ext = 1'b0; x_brk = 1'b0; x_rep = 1'b0;
    x_code = 8'h00; x_ascii = 8'h00;
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled
  task automatic model_step();
    int r;
    logic e, b;
    logic [7:0] c;
    x_ev = 1'b0; x_err = 1'b0;
    if (din_valid) begin
      idle_cnt = 0;
      seq.push_back(din);
      r = classify(seq, e, b, c);
      if (r != C_INC) seq.delete();
      if (r == C_ERR) x_err = 1'b1;
      if (r == C_EVT) begin
        x_ev = 1'b1; x_code = c; x_ext = e; x_brk = b;
        x_ascii = (!e && !b && seq.size() == 0 && c != 8'hE1) ? ascii_of(c, m_mods[0]) : 8'h00;
        if (!b) begin
          x_rep = m_last_v && (m_last == {e, c});
          m_last = {e, c}; m_last_v = 1'b1;
        end else begin
          x_rep = 1'b0;
          if (m_last == {e, c}) m_last_v = 1'b0;
        end
        if (!e && (c == 8'h12 || c == 8'h59)) m_mods[0] = !b;
        if (c == 8'h14) m_mods[1] = !b;
        if (c == 8'h11) m_mods[2] = !b;
      end
    end else if (seq.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == T) begin
        x_err = 1'b1; seq.delete(); idle_cnt = 0;
      end
    end
  endtask

  // Compare process: every negedge check outputs, then step the model
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("ev_valid", o_EventValid, x_ev);
      chk("error", o_Error, x_err);
      chk("code", o_Code, x_code);
      chk("ext", o_Extended, x_ext);
      chk("brk", o_Break, x_brk);
      chk("repeat", o_Repeat, x_rep);
      chk("ascii", o_Ascii, x_ascii);
      chk("mods", o_Mods, m_mods);
      if (o_EventValid === 1'b1) ev_seen++;
      if (o_Error === 1'b1) err_seen++;
      if (!rst) model_step();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One byte for one cycle; returns #1 after the edge that sampled it
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    din = b; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  initial begin
    int ev0, err0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mods", o_Mods, 3'b000);
    chk("rst_ev", o_EventValid, 1'b0);
    rst = 1'b0;

    // Plain make
    send(8'h1C);
    chk("a_ev", o_EventValid, 1'b1);
    chk("a_code", o_Code, 8'h1C);
    chk("a_ascii", o_Ascii, 8'h61);
    @(posedge clk); #1;
    chk("a_ev_oneshot", o_EventValid, 1'b0);
    chk("a_hold_code", o_Code, 8'h1C);

    // Shift handling
    send(8'h12);             chk("sh_mods_set", o_Mods, 3'b001);
    send(8'h1C);             chk("sh_ascii_A", o_Ascii, 8'h41);
    send(8'hF0); send(8'h1C); chk("brk_flag", o_Break, 1'b1);
    chk("brk_ascii", o_Ascii, 8'h00);
    send(8'hF0); send(8'h12); chk("sh_mods_clr", o_Mods, 3'b000);

    // Extended make/break with a fake shift in between
    send(8'hE0); send(8'h75); chk("ext_make", {o_Extended, o_Break, o_Code}, 10'h275);
    ev0 = ev_seen;
    send(8'hE0); send(8'h12); chk("fake_shift_ev", o_EventValid, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_brk", {o_Extended, o_Break, o_Code}, 10'h375);

    // Ctrl / alt, extended variants share the bit
    send(8'hE0); send(8'h14); chk("rctrl", o_Mods, 3'b010);
    send(8'h11);              chk("lalt", o_Mods, 3'b110);
    send(8'hE0); send(8'hF0); send(8'h11); chk("ralt_brk", o_Mods, 3'b010);
    send(8'hF0); send(8'h14); chk("ctrl_brk", o_Mods, 3'b000);

    // Typematic repeat
    send(8'h1C); chk("rep0", o_Repeat, 1'b0);
    send(8'h1C); chk("rep1", o_Repeat, 1'b1);
    send(8'h1C); chk("rep2", o_Repeat, 1'b1);
    send(8'hF0); send(8'h1C); chk("rep_brk", o_Repeat, 1'b0);
    send(8'h1C); chk("rep3", o_Repeat, 1'b0);
    send(8'h45); chk("digit0", o_Ascii, 8'h30);
    send(8'h5A); chk("enter", o_Ascii, 8'h0D);

    // Pause sequence: one event, no error
    repeat (2) @(posedge clk);
    ev0 = ev_seen; err0 = err_seen;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_code", o_Code, 8'hE1);
    repeat (2) @(posedge clk);
    chk("pause_events", ev_seen - ev0, 1);
    chk("pause_errors", err_seen - err0, 0);

    // Timeout after a lone F0, then a normal key
    err0 = err_seen;
    send(8'hF0);
    repeat (T + 4) @(posedge clk);
    chk("timeout_err", err_seen - err0, 1);
    send(8'h29); chk("space_after_to", o_Ascii, 8'h20);
    chk("space_brk", o_Break, 1'b0);

    // Protocol errors and ignored bytes
    err0 = err_seen;
    send(8'hF0); send(8'hF0); chk("f0f0_err", o_Error, 1'b1);
    repeat (2) @(posedge clk);
    chk("f0f0_count", err_seen - err0, 1);
    send(8'h00); chk("nul_err", o_Error, 1'b1);
    send(8'hAA); chk("bat_ignored", {o_EventValid, o_Error}, 2'b00);
    send(8'h66); chk("bksp", o_Ascii, 8'h08);

    // Async reset while in GOT_E0
    send(8'h12); send(8'hE0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_outputs", {o_EventValid, o_Code, o_Extended, o_Break, o_Repeat,
                         o_Ascii, o_Mods, o_Error}, 24'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h75); chk("post_rst_ext", o_Extended, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the raw scan-code byte stream from the PS/2 receiver, one byte per strobe.
- Resolves the set-2 prefix sequences E0, F0, E0 F0 and the E1 Pause sequence into single key events.
- Tracks modifier state, flags typematic repeats and translates a basic key subset to ASCII.
- Sits between the PS/2 receiver and the application logic (display/console).

Parameters:
- TIMEOUT_CYCLES, 50000: max i_clk cycles allowed between bytes of one multi-byte sequence (1 ms at 50 MHz).
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_Byte  in  8  received scan-code byte.
- i_ByteValid  in  1  one-cycle strobe; i_Byte is valid this cycle.
- o_EventValid  out  1  one-cycle strobe; the event fields below are valid this cycle.
- o_Code  out  8  final scan code of the event.
- o_Extended  out  1  event was E0-prefixed.
- o_Break  out  1  1 = key release, 0 = key press.
- o_Repeat  out  1  make event for a key that is already held.
- o_Ascii  out  8  ASCII code of the event; 0x00 if unmapped, extended, or a break event.
- o_Mods  out  3  {alt, ctrl, shift} held state, registered.
- o_Error  out  1  one-cycle strobe on a protocol error or timeout.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-high on i_rst.
- Reset values: all outputs 0, FSM in IDLE, modifiers cleared, last-make register cleared (valid bit 0), timeout counter 0.
- Input sampling: i_Byte is sampled only when i_ByteValid = 1.
- Latency: o_EventValid is asserted exactly 1 cycle after the strobe of the final byte of a sequence. Event fields are held until the next event.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE_SKIP.
- IDLE transitions:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - E1 -> PAUSE_SKIP with skip count 7.
  - AA, FA, EE -> ignored (BAT / ack / echo), no event.
  - 00 or FF -> o_Error pulse, stay in IDLE.
  - Any other byte -> make event, ext 0.
- GOT_E0 transitions:
  - F0 -> GOT_E0F0.
  - 12 or 59 -> discarded (fake shift), go to IDLE, no event.
  - Any other byte except E0/E1 -> make event, ext 1, go to IDLE.
- GOT_F0: any byte except E0/F0/E1 -> break event, ext 0, go to IDLE.
- GOT_E0F0:
  - 12 or 59 -> discarded, go to IDLE.
  - Any other byte except E0/F0/E1 -> break event, ext 1, go to IDLE.
- Unexpected prefix: receiving E0/F0/E1 in any non-IDLE state other than the cases above -> o_Error pulse, go to IDLE, byte dropped.
- PAUSE_SKIP: decrement the skip count on each byte. When it reaches 0, emit a make event with code E1, ext 0, ascii 0, then go to IDLE.
- Timeout: the counter clears on every strobe and increments every cycle while not in IDLE. When it reaches TIMEOUT_CYCLES: o_Error pulse, go to IDLE. If a strobe arrives in the same cycle the timeout fires, the strobe wins.
- Modifiers, updated in the same cycle as the event:
  - shift = 12 or 59 (ext 0).
  - ctrl = 14 (ext 0 or 1).
  - alt = 11 (ext 0 or 1).
  - Make sets the bit, break clears it. Left and right keys share one bit.
- Repeat:
  - A make event whose {ext, code} equals the stored last make, with the valid bit set -> o_Repeat = 1.
  - Any make stores {ext, code} and sets the valid bit.
  - A break of the stored key clears the valid bit.
- ASCII mapping (ext 0, make only):
  - Letters: 1C→a, 32→b, 21→c, 23→d, 24→e, 2B→f, 34→g, 33→h, 43→i, 3B→j, 42→k, 4B→l, 3A→m, 31→n, 44→o, 4D→p, 15→q, 2D→r, 1B→s, 2C→t, 3C→u, 2A→v, 1D→w, 22→x, 35→y, 1A→z.
  - Digits: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - Others: 29→20 (space), 5A→0D (enter), 66→08 (backspace).
  - Shift rule: letters are uppercase when shift is held (shift state before the event). Digits are unaffected by shift.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding.
  - Byte constants: E0, F0, E1, AA, FA, EE.
  - Modifier codes: 12, 59, 14, 11.
  - Bit indices of o_Mods.
- Sub-module ps2_ascii_lut: purely combinational. Inputs code[7:0] and shift; output ascii[7:0].

Test Plan:
- Reset, then byte 1C -> next cycle o_EventValid = 1, code 1C, ext 0, brk 0, ascii 0x61.
- Bytes 12, 1C, F0 1C, F0 12 -> ascii 0x41; o_Mods[0] = 1 after the 12 make and 0 after the F0 12 break; break events carry ascii 0.
- Bytes E0 75, then E0 F0 75 -> make code 75 ext 1, then break code 75 ext 1; E0 12 injected mid-stream produces no event.
- Bytes 1C, 1C, 1C, F0 1C, 1C -> o_Repeat = 0, 1, 1, (break: 0), 0.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event (code E1), no o_Error.
- Byte F0, then idle for TIMEOUT_CYCLES -> one o_Error pulse, FSM back in IDLE; a following 29 gives ascii 0x20. Separately, F0 F0 -> one o_Error pulse. Asserting i_rst while in GOT_E0 -> all outputs 0 immediately.
